// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM encoding, NOP word and
// the register-field positions decoded from the IF/ID instruction.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction when enabled, or a
// bubble when clr is also set; PC+4 is left untouched by bubbles.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc_plus4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc_plus4,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc_plus4;
  logic               r_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= INSTR_W'(NOP_INSTR);
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (i_en) begin
      if (i_clr) begin
        r_instr <= INSTR_W'(NOP_INSTR);
        r_valid <= 1'b0;
      end else begin
        r_instr    <= i_instr;
        r_pc_plus4 <= i_pc_plus4;
        r_valid    <= 1'b1;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register with req/ready instruction port, skid buffer and
// branch/jump redirect. Define FETCH_PERF_CNT_EN for fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [ADDR_W-1:0]  PCBranchD,
  input  logic               JumpD,
  input  logic [ADDR_W-1:0]  PCJumpD,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic [INSTR_W-1:0] InstrD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               ValidD,
  output logic [4:0]         RsD,
  output logic [4:0]         RtD,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall,
`endif
  output logic               FetchBusy
);

  fetch_state_e       r_state, w_state_next;
  logic [ADDR_W-1:0]  r_pcf, w_pc_next, w_pc_plus4, w_target, w_addr;
  logic [ADDR_W-1:0]  r_kill_addr, r_skid_pc4, w_ld_pc4;
  logic [INSTR_W-1:0] r_skid_instr, w_ld_instr;
  logic               w_redir, w_load, w_skid_we, w_kill_we, w_req, w_busy;

  assign w_redir    = (PCSrcD | JumpD) & ValidD & ~StallD;
  assign w_target   = JumpD ? PCJumpD : PCBranchD;
  assign w_pc_plus4 = r_pcf + ADDR_W'(4);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pcf;
    w_load       = 1'b0;
    w_ld_instr   = imem_rdata;
    w_ld_pc4     = w_pc_plus4;
    w_skid_we    = 1'b0;
    w_kill_we    = 1'b0;
    w_req        = 1'b0;
    w_busy       = 1'b0;
    w_addr       = r_pcf;
    case (r_state)
      S_REQ: begin
        w_req  = 1'b1;
        w_busy = ~imem_ready;
        if (w_redir) begin
          w_pc_next = w_target;
          if (!imem_ready) begin
            w_kill_we    = 1'b1;
            w_state_next = S_KILL;
          end
        end else if (imem_ready) begin
          w_pc_next = w_pc_plus4;
          if (StallF) begin
            w_skid_we    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!StallD) begin
          w_state_next = S_REQ;
          if (w_redir) begin
            w_pc_next = w_target;
          end else begin
            w_load     = 1'b1;
            w_ld_instr = r_skid_instr;
            w_ld_pc4   = r_skid_pc4;
          end
        end
      end
      S_KILL: begin
        // The outstanding request must complete at its original address
        // before the redirected fetch can be issued.
        w_req  = 1'b1;
        w_busy = 1'b1;
        w_addr = r_kill_addr;
        if (imem_ready) w_state_next = S_REQ;
      end
      default: w_state_next = S_REQ;
    endcase
  end

  // NOTE: skid and kill-address data registers are reset too, so a reset
  // in S_HOLD leaves nothing stale that could later be delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_REQ;
      r_pcf        <= ADDR_W'(RESET_PC);
      r_kill_addr  <= '0;
      r_skid_instr <= INSTR_W'(NOP_INSTR);
      r_skid_pc4   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pcf   <= w_pc_next;
      if (w_kill_we) r_kill_addr <= r_pcf;
      if (w_skid_we) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc4   <= w_pc_plus4;
      end
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (~StallD),
    .i_clr     (~w_load),
    .i_instr   (w_ld_instr),
    .i_pc_plus4(w_ld_pc4),
    .o_instr   (InstrD),
    .o_pc_plus4(PCPlus4D),
    .o_valid   (ValidD)
  );

  assign imem_req  = w_req & rst_n;
  assign imem_addr = w_addr;
  assign FetchBusy = w_busy;
  assign RsD       = InstrD[RS_MSB:RS_LSB];
  assign RtD       = InstrD[RT_MSB:RT_LSB];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_load && !StallD && r_perf_fetched != '1) r_perf_fetched <= r_perf_fetched + 32'd1;
      if ((StallD || w_busy) && r_perf_stall != '1)  r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: streaming, stall/skid, branch, jump
// during a memory wait, PC wrap and asynchronous reset while holding.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, PCSrcD, JumpD;
  logic [31:0] PCBranchD, PCJumpD;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_ready;
  logic [31:0] InstrD, PCPlus4D;
  logic        ValidD, FetchBusy;
  logic [4:0]  RsD, RtD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory model: each word is its address XOR a fixed pattern.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem(imem_addr);

  fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallF    (StallF),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .JumpD     (JumpD),
    .PCJumpD   (PCJumpD),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .RsD       (RsD),
    .RtD       (RtD),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall),
`endif
    .FetchBusy (FetchBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; JumpD = 1'b0;
    PCBranchD = '0; PCJumpD = '0; imem_ready = 1'b1;
    step(); step();
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, ValidD},   32'd0);
    check("rst_instr", InstrD,            32'd0);
    check("rst_pc4",   PCPlus4D,          32'd0);
    check("rst_addr",  imem_addr,         32'd0);

    rst_n = 1'b1; #1;
    check("rel_req",  {31'd0, imem_req}, 32'd1);
    check("rel_addr", imem_addr,         32'd0);

    step();  // fetched 0x0
    check("s0_instr", InstrD,          32'h1234_5678);
    check("s0_pc4",   PCPlus4D,        32'd4);
    check("s0_valid", {31'd0, ValidD}, 32'd1);
    check("s0_rs",    {27'd0, RsD},    32'd17);
    check("s0_rt",    {27'd0, RtD},    32'd20);
    check("s0_addr",  imem_addr,       32'd4);
    step();  // fetched 0x4
    check("s1_instr", InstrD,    32'h1234_567C);
    check("s1_pc4",   PCPlus4D,  32'd8);
    check("s1_addr",  imem_addr, 32'd8);

    StallF = 1'b1; StallD = 1'b1;
    step();  // 0x8 goes to skid
    check("st0_instr", InstrD,            32'h1234_567C);
    check("st0_pc4",   PCPlus4D,          32'd8);
    check("st0_req",   {31'd0, imem_req}, 32'd0);
    step(); step();
    check("st2_instr", InstrD,          32'h1234_567C);
    check("st2_valid", {31'd0, ValidD}, 32'd1);
    StallF = 1'b0; StallD = 1'b0;
    step();  // skid delivered
    check("skid_instr", InstrD,            32'h1234_5670);
    check("skid_pc4",   PCPlus4D,          32'd12);
    check("skid_req",   {31'd0, imem_req}, 32'd1);
    check("skid_addr",  imem_addr,         32'd12);
    step();  // fetched 0xC, no duplicate of 0x8
    check("post_instr", InstrD,   32'h1234_5674);
    check("post_pc4",   PCPlus4D, 32'd16);

    PCSrcD = 1'b1; PCBranchD = 32'h100;
    step();
    PCSrcD = 1'b0;
    check("br_addr",  imem_addr,       32'h100);
    check("br_instr", InstrD,          32'd0);
    check("br_valid", {31'd0, ValidD}, 32'd0);
    check("br_pc4",   PCPlus4D,        32'd16);
    step();  // fetched 0x100
    check("bt_instr", InstrD,   32'h1234_5778);
    check("bt_pc4",   PCPlus4D, 32'h104);

    imem_ready = 1'b0; JumpD = 1'b1; PCJumpD = 32'h40; #1;
    check("wait_busy", {31'd0, FetchBusy}, 32'd1);
    step();
    JumpD = 1'b0;
    check("kill0_addr",  imem_addr,          32'h104);
    check("kill0_busy",  {31'd0, FetchBusy}, 32'd1);
    check("kill0_valid", {31'd0, ValidD},    32'd0);
    check("kill0_req",   {31'd0, imem_req},  32'd1);
    step();
    check("kill1_addr",  imem_addr,       32'h104);
    check("kill1_valid", {31'd0, ValidD}, 32'd0);
    imem_ready = 1'b1;
    step();  // killed response dropped
    check("kdone_addr",  imem_addr,          32'h40);
    check("kdone_valid", {31'd0, ValidD},    32'd0);
    check("kdone_busy",  {31'd0, FetchBusy}, 32'd0);
    step();  // fetched 0x40
    check("j_instr", InstrD,   32'h1234_5638);
    check("j_pc4",   PCPlus4D, 32'h44);

    JumpD = 1'b1; PCJumpD = 32'hFFFF_FFFC; PCSrcD = 1'b1; PCBranchD = 32'h200;
    step();
    JumpD = 1'b0; PCSrcD = 1'b0;
    check("jprio_addr", imem_addr, 32'hFFFF_FFFC);
    step();  // fetched 0xFFFFFFFC
    check("wrap_instr", InstrD,          32'hEDCB_A984);
    check("wrap_pc4",   PCPlus4D,        32'd0);
    check("wrap_valid", {31'd0, ValidD}, 32'd1);
    check("wrap_addr",  imem_addr,       32'd0);
    step();  // fetched 0x0
    check("w2_addr", imem_addr, 32'd4);

    StallF = 1'b1; StallD = 1'b1;
    step();  // 0x4 goes to skid
    check("h_req", {31'd0, imem_req}, 32'd0);
    #2 rst_n = 1'b0; #1;
    check("ar_valid", {31'd0, ValidD},   32'd0);
    check("ar_instr", InstrD,            32'd0);
    check("ar_req",   {31'd0, imem_req}, 32'd0);
    StallF = 1'b0; StallD = 1'b0;
    step();
    rst_n = 1'b1; #1;
    check("ar_addr", imem_addr, 32'd0);
    step();  // fetched 0x0 from RESET_PC, not the old skid word
    check("ar_first_instr", InstrD,   32'h1234_5678);
    check("ar_first_pc4",   PCPlus4D, 32'd4);
    step();
    check("ar_next_instr", InstrD,   32'h1234_567C);
    check("ar_next_pc4",   PCPlus4D, 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
